mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch stage (I side, read-only) and the memory stage (D side, load/store).
- Sequences single-word and burst accesses: issues one word beat per cycle, routes read data back to the owner, signals completion.
- Drives the fetch stall, so the PC does not advance while instruction fetch is waiting for or using the port.
- Data side has priority, with a streak limit so fetch cannot starve.

Parameters:
- DATA_MAX, 4: maximum consecutive D grants while if_req is pending before I is forced a grant (1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; held until if_done
- if_addr  in  32  fetch start address, word aligned
- if_acc_size  in  2  burst size: 00=1, 01=4, 10=8, 11=16 words
- if_rdata  out  32  fetch read data
- if_rvalid  out  1  if_rdata valid this cycle
- if_done  out  1  one-cycle pulse with the final fetch word
- fetch_stall  out  1  stall to the fetch stage
- d_req  in  1  memory-stage request; held until d_done
- d_rw  in  1  0=read, 1=write
- d_addr  in  32  data start address, word aligned
- d_acc_size  in  2  encoding as if_acc_size
- d_wdata  in  32  current write beat data
- d_wnext  out  1  d_wdata consumed this cycle; requester advances to the next beat
- d_rdata  out  32  data read data
- d_rvalid  out  1  d_rdata valid this cycle
- d_done  out  1  one-cycle completion pulse
- m_en  out  1  memory beat strobe
- m_rw  out  1  0=read, 1=write
- m_addr  out  32  beat address
- m_wdata  out  32  beat write data
- m_acc_size  out  2  size of the owning transaction, constant for the whole burst
- m_rdata  in  32  memory read data, valid the cycle after an m_en read beat

Behaviour:
- States: IDLE, I_BURST, D_BURST.
- Registered state: owner, base address, rw, size, beat counter (5 bits), d streak counter, one-cycle read-return pipeline.

Reset (rst_n low, asynchronous, any time including mid-burst):
- State goes to IDLE; counters clear; return pipeline is flushed.
- All outputs low or zero; fetch_stall is then driven by its combinational equation.
- A burst interrupted by reset is abandoned; no done pulse is produced.

IDLE arbitration (sampled at the clock edge):
- d_req only: grant D. If if_req is also high, d streak increments, saturating at DATA_MAX.
- if_req only: grant I; streak clears.
- Both requests and streak < DATA_MAX: grant D; streak increments.
- Both requests and streak == DATA_MAX: grant I; streak clears.
- A grant latches addr, acc_size and rw (rw forced 0 for I) and clears the beat counter.

Burst states:
- m_en is high every cycle.
- m_addr = base + 4*beat, modulo 2^32 (wraps past 0xFFFFFFFC).
- Beat count N = 1/4/8/16 from acc_size.
- After beat N-1 is issued, the next state is IDLE.
- Request drops or attribute changes mid-burst are ignored; the burst always completes.

Write bursts (D only):
- m_wdata = d_wdata and d_wnext = 1 combinationally in each beat cycle.
- d_done pulses in the cycle after the last beat.

Read bursts:
- The owner's rvalid is high the cycle after each read beat, with rdata = m_rdata.
- done pulses together with the last rvalid.

Timing:
- Latency from request sampled in IDLE to first m_en is 1 cycle.
- Return to IDLE coincides with the final done/rvalid cycle. Arbitration happens in that cycle, so there is one bubble between back-to-back transactions.
- Inactive owner's rvalid and done stay 0. m_wdata is 0 when not in a write beat.

fetch_stall:
- fetch_stall = if_req & ~if_done (combinational).
- Asserted through arbitration loss and the whole I burst; deasserted in the if_done cycle.

Test Plan:
- Reset mid-burst: assert rst_n=0 during beat 2 of a D 8-word read -> m_en=0 immediately, no d_done. After release, IDLE, and a new if_req is granted 1 cycle later.
- I single fetch: if_req, if_addr=0x80020000, size=00 -> one m_en read at 0x80020000, then if_rvalid and if_done in the same cycle. fetch_stall=1 until that cycle.
- D 4-word write at 0x00001000: m_addr 0x1000, 0x1004, 0x1008, 0x100C on consecutive cycles, m_wdata follows d_wdata, d_wnext high 4 cycles, d_done the cycle after the last beat.
- Simultaneous if_req and d_req (continuous), DATA_MAX=4 -> 4 D grants, then 1 I grant, pattern repeats; fetch_stall is never high more than 4 D transactions plus bubbles.
- Wrap: D 4-word read at 0xFFFFFFF8 -> m_addr 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004.
- 16-word I burst with d_req arriving at beat 3 -> I burst completes all 16 beats, and D is granted at the if_done cycle (first D m_en one cycle later).

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every signal of the shared memory port arbiter: the instruction-fetch
// requester (if_*), the memory-stage requester (d_*) and the unified memory
// port (m_*).
//
// Modports:
//   master : the arbiter. It consumes requests and m_rdata, and drives the
//            memory port, the return data/handshakes and fetch_stall.
//   slave  : everything around the arbiter (fetch stage, memory stage and the
//            memory itself), i.e. the mirror image of master.
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;

  // Instruction-fetch side (read only)
  logic        if_req;
  logic [31:0] if_addr;
  logic [1:0]  if_acc_size;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        if_done;
  logic        fetch_stall;

  // Memory-stage side (load/store)
  logic        d_req;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [1:0]  d_acc_size;
  logic [31:0] d_wdata;
  logic        d_wnext;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_done;

  // Unified memory port
  logic        m_en;
  logic        m_rw;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_acc_size;
  logic [31:0] m_rdata;

  modport master (
    input  if_req, if_addr, if_acc_size,
    output if_rdata, if_rvalid, if_done, fetch_stall,
    input  d_req, d_rw, d_addr, d_acc_size, d_wdata,
    output d_wnext, d_rdata, d_rvalid, d_done,
    output m_en, m_rw, m_addr, m_wdata, m_acc_size,
    input  m_rdata
  );

  modport slave (
    output if_req, if_addr, if_acc_size,
    input  if_rdata, if_rvalid, if_done, fetch_stall,
    output d_req, d_rw, d_addr, d_acc_size, d_wdata,
    input  d_wnext, d_rdata, d_rvalid, d_done,
    input  m_en, m_rw, m_addr, m_wdata, m_acc_size,
    output m_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between instruction fetch (I, read only) and
// the memory stage (D, load/store). The owner of a grant gets a burst of
// 1/4/8/16 word beats, one beat per cycle. Read data returns to the owner one
// cycle after each read beat; done pulses with the final return cycle (or the
// cycle after the final write beat). D has priority, but after DATA_MAX
// consecutive D grants with fetch waiting, fetch is granted once.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mem_port_arbiter_if.master (if_*, d_*, m_* signals, fetch_stall)
//
// Parameters:
//   DATA_MAX : consecutive D grants allowed while if_req waits (1..15)
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int DATA_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.master  bus
);

  localparam logic [3:0] STREAK_MAX = 4'(DATA_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_BURST = 2'd1,
    D_BURST = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] base_q;
  logic        rw_q;
  logic [1:0]  size_q;
  logic [4:0]  beat_q;
  logic [3:0]  streak_q;

  // One-cycle return pipeline: describes the beat issued in the previous cycle.
  logic        ret_valid_q;
  logic        ret_d_q;      // 1 = beat belonged to D, 0 = to I
  logic        ret_rw_q;
  logic        ret_last_q;

  logic        in_burst;
  logic        last_beat;
  logic        write_beat;
  logic        grant_d;
  logic        grant_i;

  function automatic logic [4:0] beat_count(input logic [1:0] size);
    case (size)
      2'b00:   return 5'd1;
      2'b01:   return 5'd4;
      2'b10:   return 5'd8;
      default: return 5'd16;
    endcase
  endfunction

  assign in_burst   = (state_q != IDLE);
  assign last_beat  = in_burst && (beat_q == beat_count(size_q) - 5'd1);
  assign write_beat = (state_q == D_BURST) && rw_q;

  // D wins unless fetch is waiting and D has already used up its streak.
  assign grant_d = bus.d_req && !(bus.if_req && (streak_q == STREAK_MAX));
  assign grant_i = bus.if_req && !grant_d;

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_d)      state_d = D_BURST;
        else if (grant_i) state_d = I_BURST;
      end
      I_BURST, D_BURST: begin
        if (last_beat)    state_d = IDLE;
      end
      default:            state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q <= state_d;
    end
  end

  // Transaction attributes, beat counter and fairness streak
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q   <= '0;
      rw_q     <= 1'b0;
      size_q   <= '0;
      beat_q   <= '0;
      streak_q <= '0;
    end else if (state_q == IDLE) begin
      if (grant_d) begin
        base_q <= bus.d_addr;
        rw_q   <= bus.d_rw;
        size_q <= bus.d_acc_size;
        beat_q <= '0;
        // Streak only counts D grants that made a waiting fetch lose.
        if (bus.if_req && (streak_q != STREAK_MAX)) streak_q <= streak_q + 4'd1;
      end else if (grant_i) begin
        base_q   <= bus.if_addr;
        rw_q     <= 1'b0;
        size_q   <= bus.if_acc_size;
        beat_q   <= '0;
        streak_q <= '0;
      end
    end else begin
      beat_q <= beat_q + 5'd1;
    end
  end

  // Return pipeline: memory answers reads one cycle after the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ret_valid_q <= 1'b0;
      ret_d_q     <= 1'b0;
      ret_rw_q    <= 1'b0;
      ret_last_q  <= 1'b0;
    end else begin
      ret_valid_q <= in_burst;
      ret_d_q     <= (state_q == D_BURST);
      ret_rw_q    <= rw_q;
      ret_last_q  <= last_beat;
    end
  end

  // Memory port: address wraps modulo 2^32 by plain 32-bit addition.
  assign bus.m_en       = in_burst;
  assign bus.m_rw       = in_burst && rw_q;
  assign bus.m_addr     = in_burst ? (base_q + {25'd0, beat_q, 2'b00}) : 32'd0;
  assign bus.m_acc_size = in_burst ? size_q : 2'b00;
  assign bus.m_wdata    = write_beat ? bus.d_wdata : 32'd0;
  assign bus.d_wnext    = write_beat;

  // Return to the owner of the previous beat.
  assign bus.if_rvalid = ret_valid_q && !ret_d_q && !ret_rw_q;
  assign bus.if_done   = ret_valid_q && !ret_d_q && ret_last_q;
  assign bus.if_rdata  = bus.if_rvalid ? bus.m_rdata : 32'd0;

  assign bus.d_rvalid  = ret_valid_q && ret_d_q && !ret_rw_q;
  assign bus.d_done    = ret_valid_q && ret_d_q && ret_last_q;
  assign bus.d_rdata   = bus.d_rvalid ? bus.m_rdata : 32'd0;

  // The PC holds while fetch waits or is receiving, released on its done cycle.
  assign bus.fetch_stall = bus.if_req && !bus.if_done;

endmodule
